// File: rtl/fpu_config_loader.sv
// fpu_config_loader: fetches one 512-bit configuration line from memory on request
// and applies it to the convolution filter, image-geometry and address registers.
// Optional feature macro: FPU_CFG_TIMEOUT_EN adds a watchdog that briefly drops and
// re-raises the memory request if no return arrives within TIMEOUT_CYCLES cycles.
module fpu_config_loader #(
    parameter logic [31:0] CONFIG_ADDR    = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_config_start,
    input  logic               mapped_data_valid,
    input  logic [511:0]       data_mem,
    output logic               mapped_data_request,
    output logic [31:0]        address_mem,
    output logic               load_config_done,
    output logic signed [7:0]  filter [9],
    output logic [15:0]        image_width,
    output logic [15:0]        image_height,
    output logic [31:0]        start_address,
    output logic [31:0]        result_address
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_t;

    state_t state_q;

    // Bits above the last field carry nothing for this block.
    logic unused_data;
    assign unused_data = ^data_mem[511:168];

`ifdef FPU_CFG_TIMEOUT_EN
    logic [31:0] cnt_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    // Fetch FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q             <= StIdle;
            mapped_data_request <= 1'b0;
            address_mem         <= '0;
            load_config_done    <= 1'b0;
            for (int i = 0; i < 9; i++) filter[i] <= '0;
            image_width         <= '0;
            image_height        <= '0;
            start_address       <= '0;
            result_address      <= '0;
`ifdef FPU_CFG_TIMEOUT_EN
            cnt_q               <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    load_config_done <= 1'b0;
                    if (load_config_start) begin
                        state_q             <= StReq;
                        mapped_data_request <= 1'b1;
                        address_mem         <= CONFIG_ADDR;
`ifdef FPU_CFG_TIMEOUT_EN
                        cnt_q               <= '0;
`endif
                    end
                end
                StReq: begin
                    if (mapped_data_valid) begin
                        for (int i = 0; i < 9; i++) filter[i] <= data_mem[8*i +: 8];
                        image_width         <= data_mem[87:72];
                        image_height        <= data_mem[103:88];
                        start_address       <= data_mem[135:104];
                        result_address      <= data_mem[167:136];
                        mapped_data_request <= 1'b0;
                        address_mem         <= '0;
                        load_config_done    <= 1'b1;
                        state_q             <= StDone;
`ifdef FPU_CFG_TIMEOUT_EN
                    end else if (!mapped_data_request) begin
                        // One-cycle gap is over: re-issue with a fresh count.
                        mapped_data_request <= 1'b1;
                        cnt_q               <= '0;
                    end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                        mapped_data_request <= 1'b0;
                        cnt_q               <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
`endif
                    end
                end
                StDone: begin
                    load_config_done <= 1'b0;
                    state_q          <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_config_loader.sv
// Bench for fpu_config_loader: directed scenarios plus randomized fetches checked
// against a transaction-level model (expected line contents and request timeline).
module tb_fpu_config_loader;

    localparam logic [31:0] CFG_ADDR = 32'h0000_1000;
    localparam int          T        = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               load_config_start;
    logic               mapped_data_valid;
    logic [511:0]       data_mem;
    logic               mapped_data_request;
    logic [31:0]        address_mem;
    logic               load_config_done;
    logic signed [7:0]  filter [9];
    logic [15:0]        image_width;
    logic [15:0]        image_height;
    logic [31:0]        start_address;
    logic [31:0]        result_address;

    int checks = 0;
    int errors = 0;
    logic [167:0] exp_line = '0;

    fpu_config_loader #(
        .CONFIG_ADDR    (CFG_ADDR),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .load_config_start   (load_config_start),
        .mapped_data_valid   (mapped_data_valid),
        .data_mem            (data_mem),
        .mapped_data_request (mapped_data_request),
        .address_mem         (address_mem),
        .load_config_done    (load_config_done),
        .filter              (filter),
        .image_width         (image_width),
        .image_height        (image_height),
        .start_address       (start_address),
        .result_address      (result_address)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Configuration outputs against the last line the model says was applied.
    task automatic check_cfg(input string tag);
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s.filter%0d", tag, i), {56'b0, filter[i]}, {56'b0, exp_line[8*i +: 8]});
        chk({tag, ".width"},  {48'b0, image_width},    {48'b0, exp_line[87:72]});
        chk({tag, ".height"}, {48'b0, image_height},   {48'b0, exp_line[103:88]});
        chk({tag, ".start"},  {32'b0, start_address},  {32'b0, exp_line[135:104]});
        chk({tag, ".result"}, {32'b0, result_address}, {32'b0, exp_line[167:136]});
    endtask

    task automatic check_ctrl(input string tag, input logic req, input logic [31:0] addr,
                              input logic done);
        chk({tag, ".req"},  {63'b0, mapped_data_request}, {63'b0, req});
        chk({tag, ".addr"}, {32'b0, address_mem},         {32'b0, addr});
        chk({tag, ".done"}, {63'b0, load_config_done},    {63'b0, done});
    endtask

    // Request level k cycles after entering the fetch state.
    function automatic logic exp_req(input int k);
`ifdef FPU_CFG_TIMEOUT_EN
        return (k % (T + 1)) != T;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // One complete fetch starting from an idle DUT; valid arrives `delay` cycles
    // after the request first rises.
    task automatic fetch(input logic [511:0] line, input int delay, input bit extra_start,
                         input bit stray_valid, input logic [511:0] stray_data,
                         input bit start_in_done);
        int d = delay;
`ifdef FPU_CFG_TIMEOUT_EN
        if (d % (T + 1) == T) d++;
`endif
        load_config_start = 1'b1;
        step();
        load_config_start = 1'b0;
        for (int k = 0; k <= d; k++) begin
            check_ctrl($sformatf("req_k%0d", k), exp_req(k), CFG_ADDR, 1'b0);
            check_cfg("hold_in_req");
            mapped_data_valid = (k == d);
            data_mem          = (k == d) ? line : rand_line();
            load_config_start = extra_start && (k != d) && ($urandom_range(0, 1) == 1);
            step();
        end
        mapped_data_valid = 1'b0;
        load_config_start = start_in_done;
        exp_line = line[167:0];
        check_ctrl("done", 1'b0 | 1'b0, 32'h0, 1'b1);
        check_cfg("applied");
        step();
        load_config_start = 1'b0;
        check_ctrl("idle_after_done", 1'b0, 32'h0, 1'b0);
        check_cfg("after_done");
        if (start_in_done) begin
            step();
            check_ctrl("start_in_done_ignored", 1'b0, 32'h0, 1'b0);
        end
        if (stray_valid) begin
            mapped_data_valid = 1'b1;
            data_mem          = stray_data;
            step();
            mapped_data_valid = 1'b0;
            check_ctrl("stray_valid", 1'b0, 32'h0, 1'b0);
            check_cfg("stray_valid");
        end
    endtask

    initial begin
        logic [511:0] line;
        logic [511:0] ones;
        ones = '1;
        rst = 1'b1;
        load_config_start = 1'b0;
        mapped_data_valid = 1'b0;
        data_mem = '0;
        step();
        step();
        check_ctrl("reset", 1'b0, 32'h0, 1'b0);
        check_cfg("reset");
        rst = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check_ctrl("idle", 1'b0, 32'h0, 1'b0);

        // Basic fetch: 640x480, filter 1..9, valid 3 cycles after request rises.
        line = '0;
        for (int i = 0; i < 9; i++) line[8*i +: 8] = 8'(i + 1);
        line[87:72]   = 16'd640;
        line[103:88]  = 16'd480;
        line[135:104] = 32'h0001_0000;
        line[167:136] = 32'h0008_0000;
        line[511:168] = '1;
        fetch(line, 3, 1'b0, 1'b0, '0, 1'b0);

        // Valid coincident with the first request cycle; negative coefficient.
        line = rand_line();
        line[39:32] = 8'hF8;
        fetch(line, 0, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        assert (int'(filter[4]) === -8) else begin
            errors++;
            $error("FAIL filter4_signed: observed %0d expected -8", int'(filter[4]));
        end

        // Extra starts while busy, start during done, then a stray all-ones valid.
        fetch(rand_line(), 4, 1'b1, 1'b1, ones, 1'b1);

        // Back-to-back fetch in the first idle cycle after done.
        fetch(rand_line(), 2, 1'b0, 1'b0, '0, 1'b0);
        fetch(rand_line(), 1, 1'b0, 1'b0, '0, 1'b0);

        // Long wait: held request, or watchdog gaps when enabled.
        fetch(rand_line(), 12, 1'b0, 1'b0, '0, 1'b0);

        // Reset in the middle of a fetch; the late valid must be ignored.
        load_config_start = 1'b1;
        step();
        load_config_start = 1'b0;
        check_ctrl("pre_reset_req", 1'b1, CFG_ADDR, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp_line = '0;
        check_ctrl("async_reset", 1'b0, 32'h0, 1'b0);
        check_cfg("async_reset");
        step();
        rst = 1'b0;
        mapped_data_valid = 1'b1;
        data_mem = rand_line();
        step();
        mapped_data_valid = 1'b0;
        check_ctrl("late_valid", 1'b0, 32'h0, 1'b0);
        check_cfg("late_valid");
        step();
        check_ctrl("late_valid_next", 1'b0, 32'h0, 1'b0);

        // Randomized fetches.
        for (int n = 0; n < 20; n++)
            fetch(rand_line(), int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), rand_line(), 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_config_loader.md
FPU_CONFIG_LOADER -- requirements
Module: fpu_config_loader

Interface
REQ-001 Parameter CONFIG_ADDR, default 32'h0000_1000: memory address of the 512-bit FPU configuration line.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: watchdog limit, used only when FPU_CFG_TIMEOUT_EN is defined.
REQ-003 Clocking SHALL be one clock; reset SHALL be asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 load_config_start  input  1  single-cycle request to fetch and apply a new configuration.
REQ-007 mapped_data_valid  input  1  memory return strobe; data_mem is valid in the same cycle.
REQ-008 data_mem  input  512  returned configuration line.
REQ-009 mapped_data_request  output  1  memory read request, held until accepted.
REQ-010 address_mem  output  32  read address.
REQ-011 load_config_done  output  1  one-cycle pulse when new configuration is applied.
REQ-012 filter  output  9x8 signed  3x3 convolution coefficients, filter[0..8].
REQ-013 image_width, image_height  output  16 each  image dimensions in pixels.
REQ-014 start_address, result_address  output  32 each  source and destination image base addresses.

Function
REQ-015 FSM states SHALL be IDLE, REQ, DONE; reset state IDLE.
REQ-016 IDLE: load_config_start=1 SHALL transition to REQ next cycle; otherwise remain in IDLE.
REQ-017 REQ: mapped_data_request=1 and address_mem=CONFIG_ADDR, registered, first asserted the cycle after start.
REQ-018 REQ: mapped_data_valid=1 SHALL capture data_mem into the output registers and transition to DONE; otherwise remain in REQ with the request held.
REQ-019 Field map: filter[i]=data_mem[8i+7:8i] for i=0..8; image_width=[87:72]; image_height=[103:88]; start_address=[135:104]; result_address=[167:136]; bits [511:168] ignored.
REQ-020 DONE: load_config_done=1 for exactly one cycle, then unconditional transition to IDLE.
REQ-021 Latency: valid sampled in cycle M SHALL produce updated outputs and load_config_done=1 in cycle M+1.
REQ-022 mapped_data_request and address_mem SHALL be 0 in IDLE and DONE.
REQ-023 Configuration outputs SHALL hold their last captured values until the next capture.
REQ-024 load_config_start in REQ or DONE SHALL be ignored and SHALL NOT be queued.
REQ-025 mapped_data_valid in IDLE or DONE SHALL be ignored; outputs SHALL remain unchanged.
REQ-026 load_config_start in the cycle after load_config_done (IDLE) SHALL start a new fetch normally.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE and drive every output to 0: request, address, done, filter, dimensions, addresses.
REQ-028 Reset during REQ SHALL abandon the fetch; a late mapped_data_valid after reset release SHALL be ignored.

Configuration
REQ-029 Macro FPU_CFG_TIMEOUT_EN enables a REQ-state watchdog counter, cleared on entry to REQ.
REQ-030 With FPU_CFG_TIMEOUT_EN: after TIMEOUT_CYCLES REQ cycles without valid, mapped_data_request SHALL drop for one cycle, then reassert with the counter cleared (retry indefinitely).
REQ-031 Without FPU_CFG_TIMEOUT_EN: no counter; request held indefinitely until valid.

Verification
REQ-032 Start at cycle 10, valid at 14 with width=640, height=480, start=32'h0001_0000, result=32'h0008_0000, filter=1..9 -> request high cycles 11-14, outputs match and done=1 at cycle 15 only.
REQ-033 Valid in the same cycle the request first rises, filter[4]=8'hF8 -> filter[4] reads -8 and done at next cycle.
REQ-034 Second start pulse during REQ, and valid during IDLE with data 512'hFF..FF -> single done pulse; stray valid leaves outputs unchanged.
REQ-035 rst asserted mid-REQ, valid at the following cycle after release -> all outputs 0, state IDLE, no done pulse.
REQ-036 With FPU_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=4, no valid -> request high 4 cycles, low 1 cycle, high again; valid then completes normally.
